// File: rtl/riscv_alu_seq_pkg.sv
// Shared types for the sequential RISC-V ALU: operation and branch-compare
// encodings plus small classification helpers used by the ALU and its
// iterative multiply/divide unit.
package riscv_package;

   // Base RV32I ALU operations followed by the M-extension operations.
   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_SLL    = 5'd2,
      ALU_SLT    = 5'd3,
      ALU_SLTU   = 5'd4,
      ALU_XOR    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_OR     = 5'd8,
      ALU_AND    = 5'd9,
      ALU_MUL    = 5'd10,
      ALU_MULH   = 5'd11,
      ALU_MULHSU = 5'd12,
      ALU_MULHU  = 5'd13,
      ALU_DIV    = 5'd14,
      ALU_DIVU   = 5'd15,
      ALU_REM    = 5'd16,
      ALU_REMU   = 5'd17
   } alu_func_t;

   // Branch comparison select; BR_NONE means no branch is evaluated.
   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_BLT  = 3'd3,
      BR_BGE  = 3'd4,
      BR_BLTU = 3'd5,
      BR_BGEU = 3'd6
   } branch_t;

   function automatic logic is_mul(input alu_func_t f);
      return f inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
   endfunction

   function automatic logic is_div(input alu_func_t f);
      return f inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   endfunction

endpackage

// File: rtl/riscv_muldiv_iter.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider
// sharing one datapath. Signed operations run on operand magnitudes and the
// sign is applied to the final step's value, so the result is presented
// combinationally in the cycle `done` is high (XLEN cycles after start).
module riscv_muldiv_iter
   import riscv_package::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            clear,
   input  logic            start,
   input  alu_func_t       op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   logic            running;
   logic [CW-1:0]   count;
   alu_func_t       op_q;
   logic            div_q;
   logic            neg_lo_q;    // negate product / quotient
   logic            neg_rem_q;   // negate remainder
   logic            div_zero_q;
   logic [XLEN-1:0] hi_q;        // product high half / partial remainder
   logic [XLEN-1:0] lo_q;        // multiplier & product low half / quotient
   logic [XLEN-1:0] opd_q;       // multiplicand / divisor magnitude

   logic            sign_a;
   logic            sign_b;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift;
   logic [XLEN:0]   div_trial;
   logic [XLEN-1:0] hi_nxt;
   logic [XLEN-1:0] lo_nxt;
   logic [2*XLEN-1:0] product;
   logic [2*XLEN-1:0] product_fix;
   logic [XLEN-1:0] quotient_fix;
   logic [XLEN-1:0] remainder_fix;

   // Operand signs and magnitudes for the request being started.
   always_comb begin
      sign_a = (op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM}) && a[XLEN-1];
      sign_b = (op inside {ALU_MULH, ALU_DIV, ALU_REM}) && b[XLEN-1];
      mag_a  = sign_a ? (~a + 1'b1) : a;
      mag_b  = sign_b ? (~b + 1'b1) : b;
   end

   // One multiply or divide step from the current datapath registers.
   // NOTE: every variable gets a value before any branch so no latch is inferred.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
      div_shift = {hi_q, lo_q[XLEN-1]};
      div_trial = div_shift - {1'b0, opd_q};
      hi_nxt    = hi_q;
      lo_nxt    = lo_q;
      if (div_q) begin
         if (div_trial[XLEN]) begin
            hi_nxt = div_shift[XLEN-1:0];
            lo_nxt = {lo_q[XLEN-2:0], 1'b0};
         end else begin
            hi_nxt = div_trial[XLEN-1:0];
            lo_nxt = {lo_q[XLEN-2:0], 1'b1};
         end
      end else begin
         hi_nxt = mul_sum[XLEN:1];
         lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};
      end
   end

   // Sign fix-up and result selection from the final step's values.
   always_comb begin
      product       = {hi_nxt, lo_nxt};
      product_fix   = neg_lo_q  ? (~product + 1'b1) : product;
      quotient_fix  = neg_lo_q  ? (~lo_nxt + 1'b1)  : lo_nxt;
      remainder_fix = neg_rem_q ? (~hi_nxt + 1'b1)  : hi_nxt;
      result        = '0;
      case (op_q)
         ALU_MUL:                         result = product_fix[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU: result = product_fix[2*XLEN-1:XLEN];
         ALU_DIV, ALU_DIVU:               result = div_zero_q ? '1 : quotient_fix;
         ALU_REM, ALU_REMU:               result = remainder_fix;
         default:                         result = '0;
      endcase
   end

   assign done = running && (count == CW'(XLEN - 1));

   // Load operands on start, then advance one step per cycle until done.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (clear) begin
         running    <= 1'b0;
         count      <= '0;
         op_q       <= ALU_ADD;
         div_q      <= 1'b0;
         neg_lo_q   <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         opd_q      <= '0;
      end else if (start) begin
         running    <= 1'b1;
         count      <= '0;
         op_q       <= op;
         div_q      <= is_div(op);
         neg_lo_q   <= sign_a ^ sign_b;
         neg_rem_q  <= sign_a;
         div_zero_q <= (b == '0);
         hi_q       <= '0;
         lo_q       <= mag_a;
         opd_q      <= mag_b;
      end else if (running) begin
         hi_q  <= hi_nxt;
         lo_q  <= lo_nxt;
         count <= count + 1'b1;
         if (done) running <= 1'b0;
      end
   end

endmodule

// File: rtl/riscv_alu_seq.sv
// Sequential RISC-V ALU with valid/ready handshakes. Single-cycle operations
// and branch compares complete with latency 1; multiply/divide run through
// the iterative unit and complete XLEN+1 cycles after acceptance.
module riscv_alu_seq
   import riscv_package::*;
#(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  alu_func_t       alu_func,
   input  branch_t         branch,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            br_result,
   output logic            busy
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [XLEN-1:0] result_q;
   logic            br_q;
   logic            accept;
   logic            md_op;
   logic            md_done;
   logic [XLEN-1:0] md_result;
   logic [XLEN-1:0] alu_res;
   logic            br_nxt;
   logic [SHW-1:0]  shamt;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state == S_MUL) || (state == S_DIV);
   assign result    = result_q;
   assign br_result = br_q;

   // A flush in the same cycle as a request drops the request.
   assign accept = in_valid && in_ready && !flush;
   assign md_op  = is_mul(alu_func) || is_div(alu_func);
   assign shamt  = b[SHW-1:0];

   riscv_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
      .clk    (clk),
      .clear  (rst || flush),
      .start  (accept && md_op),
      .op     (alu_func),
      .a      (a),
      .b      (b),
      .done   (md_done),
      .result (md_result)
   );

   // Single-cycle ALU result for the incoming request.
   always_comb begin
      alu_res = '0;
      case (alu_func)
         ALU_ADD:  alu_res = a + b;
         ALU_SUB:  alu_res = a - b;
         ALU_SLL:  alu_res = a << shamt;
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
         ALU_XOR:  alu_res = a ^ b;
         ALU_SRL:  alu_res = a >> shamt;
         ALU_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
         ALU_OR:   alu_res = a | b;
         ALU_AND:  alu_res = a & b;
         default:  alu_res = '0;
      endcase
   end

   // Branch comparison for the incoming request.
   always_comb begin
      br_nxt = 1'b0;
      case (branch)
         BR_BEQ:  br_nxt = (a == b);
         BR_BNE:  br_nxt = (a != b);
         BR_BLT:  br_nxt = ($signed(a) <  $signed(b));
         BR_BGE:  br_nxt = ($signed(a) >= $signed(b));
         BR_BLTU: br_nxt = (a <  b);
         BR_BGEU: br_nxt = (a >= b);
         default: br_nxt = 1'b0;
      endcase
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (is_mul(alu_func))      state_nxt = S_MUL;
               else if (is_div(alu_func)) state_nxt = S_DIV;
               else                       state_nxt = S_DONE;
            end
         end
         S_MUL, S_DIV: if (md_done)   state_nxt = S_DONE;
         S_DONE:       if (out_ready) state_nxt = S_IDLE;
         default:                     state_nxt = S_IDLE;
      endcase
      if (flush) state_nxt = S_IDLE;
   end

   // State, result and branch registers; reset outranks flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         result_q <= '0;
         br_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            br_q <= br_nxt;
            if (!md_op) result_q <= alu_res;
         end
         if (busy && md_done && !flush) result_q <= md_result;
      end
   end

endmodule
